// File: rtl/fp_operand_aligner.sv
// Two-stage FP add/sub front end: unpack/compare, then align the smaller mantissa with G/R/S.
// Optional special-operand decode is compiled in with `define ALIGN_SPECIALS_EN.
module fp_operand_aligner (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        op_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [26:0] mant_big_o,
    output logic [26:0] mant_small_o,
    output logic [7:0]  exp_result_o,
    output logic        result_sign_o,
    output logic        eff_sub_o,
    output logic        swapped_o,
    output logic        special_o,
    output logic [31:0] special_result_o
);

    // Handshake
    logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic s1_load, s2_load;

    always_comb begin
        in_ready_o  = ~s1_valid_q | ~s2_valid_q | out_ready_i;
        s1_load     = in_valid_i & in_ready_o;
        s2_load     = s1_valid_q & (~s2_valid_q | out_ready_i);
        s1_valid_d  = s1_load | (s1_valid_q & ~s2_load);
        s2_valid_d  = s2_load | (s2_valid_q & ~out_ready_i);
        out_valid_o = s2_valid_q;
    end

    // Stage 1: unpack and order by magnitude
    logic        sign_a, sign_b_eff, swap, eff_sub, both_zero;
    logic [7:0]  exp_a, exp_b, eexp_a, eexp_b, exp_small;
    logic [22:0] frac_a, frac_b;
    logic [23:0] m_a, m_b;

    logic [23:0] s1_mant_big_d, s1_mant_big_q, s1_mant_small_d, s1_mant_small_q;
    logic [7:0]  s1_exp_d, s1_exp_q, s1_shift_d, s1_shift_q;
    logic        s1_sign_d, s1_sign_q, s1_eff_sub_d, s1_eff_sub_q;
    logic        s1_swapped_d, s1_swapped_q, s1_special_d, s1_special_q;
    logic [31:0] s1_special_result_d, s1_special_result_q;

    always_comb begin
        sign_a     = op_a_i[31];
        sign_b_eff = op_b_i[31] ^ op_i;
        exp_a      = op_a_i[30:23];
        exp_b      = op_b_i[30:23];
        frac_a     = op_a_i[22:0];
        frac_b     = op_b_i[22:0];
        // Subnormals share the exponent of the smallest normal
        eexp_a     = (exp_a == 8'd0) ? 8'd1 : exp_a;
        eexp_b     = (exp_b == 8'd0) ? 8'd1 : exp_b;
        m_a        = {exp_a != 8'd0, frac_a};
        m_b        = {exp_b != 8'd0, frac_b};
        swap       = op_b_i[30:0] > op_a_i[30:0];
        eff_sub    = sign_a ^ sign_b_eff;
        both_zero  = (op_a_i[30:0] == 31'd0) && (op_b_i[30:0] == 31'd0);

        s1_swapped_d = swap;
        s1_eff_sub_d = eff_sub;
        if (swap) begin
            s1_mant_big_d   = m_b;
            s1_mant_small_d = m_a;
            s1_exp_d        = eexp_b;
            exp_small       = eexp_a;
            s1_sign_d       = sign_b_eff;
        end else begin
            s1_mant_big_d   = m_a;
            s1_mant_small_d = m_b;
            s1_exp_d        = eexp_a;
            exp_small       = eexp_b;
            s1_sign_d       = sign_a;
        end
        s1_shift_d = s1_exp_d - exp_small;
        if (both_zero) begin
            s1_sign_d = ~eff_sub & sign_a & sign_b_eff;
        end
    end

`ifdef ALIGN_SPECIALS_EN
    logic nan_a, nan_b, inf_a, inf_b;

    always_comb begin
        nan_a = (exp_a == 8'hFF) && (frac_a != 23'd0);
        nan_b = (exp_b == 8'hFF) && (frac_b != 23'd0);
        inf_a = (exp_a == 8'hFF) && (frac_a == 23'd0);
        inf_b = (exp_b == 8'hFF) && (frac_b == 23'd0);
        s1_special_d        = 1'b0;
        s1_special_result_d = 32'd0;
        if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) begin
            s1_special_d        = 1'b1;
            s1_special_result_d = 32'h7FC0_0000;
        end else if (inf_a) begin
            // Also covers both-Inf with equal effective signs
            s1_special_d        = 1'b1;
            s1_special_result_d = {sign_a, 8'hFF, 23'd0};
        end else if (inf_b) begin
            s1_special_d        = 1'b1;
            s1_special_result_d = {sign_b_eff, 8'hFF, 23'd0};
        end
    end
`else
    always_comb begin
        s1_special_d        = 1'b0;
        s1_special_result_d = 32'd0;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q          <= 1'b0;
            s1_mant_big_q       <= '0;
            s1_mant_small_q     <= '0;
            s1_exp_q            <= '0;
            s1_shift_q          <= '0;
            s1_sign_q           <= 1'b0;
            s1_eff_sub_q        <= 1'b0;
            s1_swapped_q        <= 1'b0;
            s1_special_q        <= 1'b0;
            s1_special_result_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                s1_mant_big_q       <= s1_mant_big_d;
                s1_mant_small_q     <= s1_mant_small_d;
                s1_exp_q            <= s1_exp_d;
                s1_shift_q          <= s1_shift_d;
                s1_sign_q           <= s1_sign_d;
                s1_eff_sub_q        <= s1_eff_sub_d;
                s1_swapped_q        <= s1_swapped_d;
                s1_special_q        <= s1_special_d;
                s1_special_result_q <= s1_special_result_d;
            end
        end
    end

    // Stage 2: right-align the smaller mantissa, folding lost bits into sticky
    logic [26:0] m_small_ext, shifted, lost_mask, aligned;
    logic [4:0]  sh;

    always_comb begin
        m_small_ext = {s1_mant_small_q, 3'b000};
        sh          = s1_shift_q[4:0];
        shifted     = m_small_ext >> sh;
        lost_mask   = ~(27'h7FF_FFFF << sh);
        if (s1_shift_q >= 8'd27) begin
            aligned = {26'd0, |m_small_ext};
        end else begin
            aligned = {shifted[26:1], shifted[0] | (|(m_small_ext & lost_mask))};
        end
    end

    logic [26:0] mant_big_q, mant_small_q;
    logic [7:0]  exp_result_q;
    logic        result_sign_q, eff_sub_q, swapped_q, special_q;
    logic [31:0] special_result_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q       <= 1'b0;
            mant_big_q       <= '0;
            mant_small_q     <= '0;
            exp_result_q     <= '0;
            result_sign_q    <= 1'b0;
            eff_sub_q        <= 1'b0;
            swapped_q        <= 1'b0;
            special_q        <= 1'b0;
            special_result_q <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                mant_big_q       <= {s1_mant_big_q, 3'b000};
                mant_small_q     <= aligned;
                exp_result_q     <= s1_exp_q;
                result_sign_q    <= s1_sign_q;
                eff_sub_q        <= s1_eff_sub_q;
                swapped_q        <= s1_swapped_q;
                special_q        <= s1_special_q;
                special_result_q <= s1_special_result_q;
            end
        end
    end

    always_comb begin
        mant_big_o       = mant_big_q;
        mant_small_o     = mant_small_q;
        exp_result_o     = exp_result_q;
        result_sign_o    = result_sign_q;
        eff_sub_o        = eff_sub_q;
        swapped_o        = swapped_q;
        special_o        = special_q;
        special_result_o = special_result_q;
    end

endmodule

// File: tb/tb_fp_operand_aligner.sv
// Randomized self-checking bench for fp_operand_aligner against an arithmetic reference model.
module tb_fp_operand_aligner;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] op_a, op_b, special_result;
    logic [26:0] mant_big, mant_small;
    logic [7:0]  exp_result;
    logic        result_sign, eff_sub, swapped, special;

    fp_operand_aligner dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .op_a_i           (op_a),
        .op_b_i           (op_b),
        .op_i             (op),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .mant_big_o       (mant_big),
        .mant_small_o     (mant_small),
        .exp_result_o     (exp_result),
        .result_sign_o    (result_sign),
        .eff_sub_o        (eff_sub),
        .swapped_o        (swapped),
        .special_o        (special),
        .special_result_o (special_result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [26:0] mb;
        logic [26:0] ms;
        logic [7:0]  e;
        logic        sgn;
        logic        sub;
        logic        swp;
        logic        spc;
        logic [31:0] sres;
    } res_t;

    res_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic longint unsigned unpack_m(input logic [31:0] x);
        return (((x[30:23] != 8'd0) ? 64'd8388608 : 64'd0) + 64'(x[22:0])) * 64'd8;
    endfunction

    function automatic int unsigned eff_e(input logic [31:0] x);
        return (x[30:23] == 8'd0) ? 1 : 32'(x[30:23]);
    endfunction

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub_op);
        res_t              r;
        logic              sa, sb, swp;
        logic [31:0]       big, sml;
        int unsigned       d;
        longint unsigned   msml, p, q, rem, ms;
        sa   = a[31];
        sb   = b[31] ^ sub_op;
        swp  = 32'(b[30:0]) > 32'(a[30:0]);
        big  = swp ? b : a;
        sml  = swp ? a : b;
        d    = eff_e(big) - eff_e(sml);
        msml = unpack_m(sml);
        if (d >= 27) begin
            ms = (msml != 0) ? 64'd1 : 64'd0;
        end else begin
            p   = 64'd1 << d;
            q   = msml / p;
            rem = msml % p;
            ms  = q | ((rem != 0) ? 64'd1 : 64'd0);
        end
        r.mb   = 27'(unpack_m(big));
        r.ms   = 27'(ms);
        r.e    = 8'(eff_e(big));
        r.sub  = sa ^ sb;
        r.swp  = swp;
        r.sgn  = swp ? sb : sa;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) r.sgn = r.sub ? 1'b0 : (sa & sb);
        r.spc  = 1'b0;
        r.sres = 32'd0;
`ifdef ALIGN_SPECIALS_EN
        begin
            logic nan_a, nan_b, inf_a, inf_b;
            nan_a = a[30:23] == 8'hFF && a[22:0] != 0;
            nan_b = b[30:23] == 8'hFF && b[22:0] != 0;
            inf_a = a[30:23] == 8'hFF && a[22:0] == 0;
            inf_b = b[30:23] == 8'hFF && b[22:0] == 0;
            if (nan_a || nan_b || (inf_a && inf_b && sa != sb)) begin
                r.spc  = 1'b1;
                r.sres = 32'h7FC00000;
            end else if (inf_a || inf_b) begin
                r.spc  = 1'b1;
                r.sres = {inf_a ? sa : sb, 8'hFF, 23'd0};
            end
        end
`endif
        return r;
    endfunction

    function automatic logic [31:0] rand_op(input logic [31:0] ref_op);
        int e;
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: begin
                e = int'(ref_op[30:23]) + int'($urandom_range(0, 40)) - 20;
                if (e < 0) e = 0;
                if (e > 254) e = 254;
                return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
            end
            2: return {1'($urandom_range(0, 1)), 31'd0};
            3: return {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)};
            default: return ref_op ^ {1'($urandom_range(0, 1)), 31'd0};
        endcase
    endfunction

    // Scoreboard: push on input transfer, compare on output transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'(1'b0));
                end else begin
                    res_t x;
                    x = q_exp.pop_front();
                    if (!x.spc) begin
                        check("sb_mant_big", 64'(mant_big), 64'(x.mb));
                        check("sb_mant_small", 64'(mant_small), 64'(x.ms));
                        check("sb_exp", 64'(exp_result), 64'(x.e));
                        check("sb_sign", 64'(result_sign), 64'(x.sgn));
                    end
                    check("sb_eff_sub", 64'(eff_sub), 64'(x.sub));
                    check("sb_swapped", 64'(swapped), 64'(x.swp));
                    check("sb_special", 64'(special), 64'(x.spc));
                    check("sb_special_result", 64'(special_result), 64'(x.sres));
                end
            end
            if (in_valid && in_ready) q_exp.push_back(model(op_a, op_b, op));
        end
    end

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic o, input logic [26:0] xmb, input logic [26:0] xms,
                           input logic [7:0] xe, input logic xsgn, input logic xsub,
                           input logic xswp);
        @(posedge clk);
        #1;
        op_a = a; op_b = b; op = o; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat_early"}, 64'(out_valid), 64'(1'b0));
        @(negedge clk);
        check({tag, "_lat_valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, "_mant_big"}, 64'(mant_big), 64'(xmb));
        check({tag, "_mant_small"}, 64'(mant_small), 64'(xms));
        check({tag, "_exp"}, 64'(exp_result), 64'(xe));
        check({tag, "_sign"}, 64'(result_sign), 64'(xsgn));
        check({tag, "_eff_sub"}, 64'(eff_sub), 64'(xsub));
        check({tag, "_swapped"}, 64'(swapped), 64'(xswp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ops[4];
        logic        acc;
        int          cnt;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0; op = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_in_ready", 64'(in_ready), 64'(1'b1));
        check("rst_mant_big", 64'(mant_big), 64'd0);
        check("rst_special", 64'(special), 64'd0);
        check("rst_special_result", 64'(special_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_one("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 27'h4000000, 27'h4000000,
                8'd127, 1'b0, 1'b0, 1'b0);
        run_one("one_plus_half", 32'h3F800000, 32'h3F000000, 1'b0, 27'h4000000, 27'h2000000,
                8'd127, 1'b0, 1'b0, 1'b0);
        run_one("half_plus_one", 32'h3F000000, 32'h3F800000, 1'b0, 27'h4000000, 27'h2000000,
                8'd127, 1'b0, 1'b0, 1'b1);
        run_one("sticky_d30", 32'h3F800000, 32'h30800000, 1'b1, 27'h4000000, 27'h0000001,
                8'd127, 1'b0, 1'b1, 1'b0);
        run_one("one_minus_two", 32'h3F800000, 32'h40000000, 1'b1, 27'h4000000, 27'h2000000,
                8'd128, 1'b1, 1'b1, 1'b1);
        run_one("negz_minus_z", 32'h80000000, 32'h00000000, 1'b1, 27'h0, 27'h0,
                8'd1, 1'b1, 1'b0, 1'b0);
        run_one("z_minus_z", 32'h00000000, 32'h00000000, 1'b1, 27'h0, 27'h0,
                8'd1, 1'b0, 1'b1, 1'b0);

`ifdef ALIGN_SPECIALS_EN
        @(posedge clk);
        #1;
        op_a = 32'h7F800000; op_b = 32'h7F800000; op = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("inf_minus_inf_special", 64'(special), 64'(1'b1));
        check("inf_minus_inf_result", 64'(special_result), 64'h7FC00000);
`endif

        // Backpressure: fill both stages, hold, then drain with concurrent input
        for (int k = 0; k < 4; k++) ops[k] = rand_op(32'h3F800000);
        @(posedge clk);
        #1;
        out_ready = 1'b0; in_valid = 1'b1; op = 1'b0; op_a = ops[0]; op_b = ops[1];
        @(posedge clk);
        #1;
        op_a = ops[1]; op_b = ops[2];
        @(posedge clk);
        #1;
        op_a = ops[2]; op_b = ops[3];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'(1'b0));
            check("stall_out_valid", 64'(out_valid), 64'(1'b1));
            if (q_exp.size() > 0 && !q_exp[0].spc) begin
                check("stall_hold_mant", 64'(mant_big), 64'(q_exp[0].mb));
                check("stall_hold_small", 64'(mant_small), 64'(q_exp[0].ms));
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("burst_valid%0d", k), 64'(out_valid), 64'(1'b1));
            @(posedge clk);
            #1;
            if (k == 0) begin
                op_a = ops[3]; op_b = ops[0];
            end else if (k == 1) begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("burst_drained", 64'(q_exp.size()), 64'd0);

        // Reset with two operations in flight
        @(posedge clk);
        #1;
        out_ready = 1'b0; in_valid = 1'b1; op_a = rand_op(32'h40000000); op_b = $urandom;
        @(posedge clk);
        #1;
        op_a = $urandom;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(1'b0));
        check("midrst_in_ready", 64'(in_ready), 64'(1'b1));
        check("midrst_mant_small", 64'(mant_small), 64'd0);
        check("midrst_exp", 64'(exp_result), 64'd0);
        q_exp.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        run_one("after_rst", 32'h3F800000, 32'h3F000000, 1'b0, 27'h4000000, 27'h2000000,
                8'd127, 1'b0, 1'b0, 1'b0);

        // Random traffic with random backpressure
        acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                op_b     = rand_op(op_a);
                op_a     = rand_op(op_b);
                op       = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        while (q_exp.size() != 0 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("final_drain", 64'(q_exp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
